// File: rtl/riscv_regfile_sb_pkg.sv
// Shared constants and types for the RISC-V integer register file and its scoreboard.
// Latency: n/a (package only).
// Backpressure: n/a. Used by riscv_regfile_sb, riscv_rf_scoreboard and riscv_regfile_sb_if.
package riscv_rf_pkg;

    localparam int DEF_XLEN     = 32;
    localparam int DEF_MAX_PEND = 3;

    // Architectural register indices with a fixed role.
    localparam int REG_ZERO = 0;
    localparam int REG_RA   = 1;
    localparam int REG_SP   = 2;
    localparam int REG_T4   = 29;

    // Pending-write counter wide enough for the default MAX_PEND.
    typedef logic [$clog2(DEF_MAX_PEND + 1)-1:0] pend_cnt_t;

endpackage

// File: rtl/riscv_regfile_sb_if.sv
// Bundle of read, issue and write-back signals between the pipeline and the register file.
// Latency: n/a (wiring only). Ports: read addr/data/busy, issue en/addr/ready, wb en/addr/data, flush, debug taps.
// Backpressure: iss_ready_o gates issue; write-back is never stalled.
interface riscv_regfile_sb_if
    import riscv_rf_pkg::*;
#(
    parameter int XLEN = DEF_XLEN,
    parameter int NREG = 32,
    parameter int NRD  = 2
);
    localparam int AW = $clog2(NREG);

    logic [NRD*AW-1:0]   rs_addr_i;
    logic [NRD*XLEN-1:0] rs_data_o;
    logic [NRD-1:0]      rs_busy_o;
    logic                iss_en_i;
    logic [AW-1:0]       iss_addr_i;
    logic                iss_ready_o;
    logic                wb_en_i;
    logic [AW-1:0]       wb_addr_i;
    logic [XLEN-1:0]     wb_data_i;
    logic                flush_i;
    logic [NREG-1:0]     busy_o;
    logic                wb_err_o;
    logic [XLEN-1:0]     ra_o;
    logic [XLEN-1:0]     sp_o;
    logic [XLEN-1:0]     result_o;

    // Register-file side.
    modport slave (
        input  rs_addr_i, iss_en_i, iss_addr_i, wb_en_i, wb_addr_i, wb_data_i, flush_i,
        output rs_data_o, rs_busy_o, iss_ready_o, busy_o, wb_err_o, ra_o, sp_o, result_o
    );

    // Pipeline side.
    modport master (
        output rs_addr_i, iss_en_i, iss_addr_i, wb_en_i, wb_addr_i, wb_data_i, flush_i,
        input  rs_data_o, rs_busy_o, iss_ready_o, busy_o, wb_err_o, ra_o, sp_o, result_o
    );

endinterface

// File: rtl/riscv_regfile_sb_scoreboard.sv
// Per-register saturating pending-write counters for RAW hazard detection.
// Latency: counters/wb_err_o update 1 cycle after issue/wb; iss_ready_o and busy_o are direct from state.
// Backpressure: iss_ready_o=0 when the addressed counter is at MAX_PEND; a dropped issue leaves the count alone.
// Ports: clk_i/rst_ni, issue en/addr/ready, wb en/addr, flush, busy vector, wb_err pulse,
// and with RISCV_RF_BYPASS_EN a per-register "last producer retires this cycle" vector.
module riscv_rf_scoreboard
    import riscv_rf_pkg::*;
#(
    parameter int NREG     = 32,
    parameter int MAX_PEND = DEF_MAX_PEND
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    iss_en_i,
    input  logic [$clog2(NREG)-1:0] iss_addr_i,
    output logic                    iss_ready_o,
    input  logic                    wb_en_i,
    input  logic [$clog2(NREG)-1:0] wb_addr_i,
    input  logic                    flush_i,
    output logic [NREG-1:0]         busy_o,
`ifdef RISCV_RF_BYPASS_EN
    output logic [NREG-1:0]         retire_o,
`endif
    output logic                    wb_err_o
);

    localparam int AW = $clog2(NREG);
    localparam int CW = $clog2(MAX_PEND + 1);

    logic [CW-1:0]   cnt_q [NREG];
    logic [CW-1:0]   cnt_d [NREG];
    logic            wb_err_q, wb_err_d;
    logic            iss_rdy;
    logic [NREG-1:0] inc;
    logic [NREG-1:0] dec;

    always_comb begin
        // A write-back in the same cycle cannot free a slot for this issue: ready looks at the stored count only.
        iss_rdy = (iss_addr_i == AW'(REG_ZERO)) || (cnt_q[iss_addr_i] != CW'(MAX_PEND));
        for (int r = 0; r < NREG; r++) begin
            inc[r]   = iss_en_i && iss_rdy && (iss_addr_i == AW'(r)) && (r != REG_ZERO);
            dec[r]   = wb_en_i && (wb_addr_i == AW'(r)) && (cnt_q[r] != '0);
            cnt_d[r] = cnt_q[r];
            if (flush_i) begin
                cnt_d[r] = '0;
            end else if (inc[r] && !dec[r]) begin
                cnt_d[r] = cnt_q[r] + CW'(1);
            end else if (dec[r] && !inc[r]) begin
                cnt_d[r] = cnt_q[r] - CW'(1);
            end
        end
        // Write-back with nothing outstanding: data still lands, counter holds at 0.
        wb_err_d = wb_en_i && (wb_addr_i != AW'(REG_ZERO)) && (cnt_q[wb_addr_i] == '0) && !flush_i;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int r = 0; r < NREG; r++) begin
                cnt_q[r] <= '0;
            end
            wb_err_q <= 1'b0;
        end else begin
            for (int r = 0; r < NREG; r++) begin
                cnt_q[r] <= cnt_d[r];
            end
            wb_err_q <= wb_err_d;
        end
    end

    always_comb begin
        for (int r = 0; r < NREG; r++) begin
            busy_o[r] = (cnt_q[r] != '0);
        end
    end

`ifdef RISCV_RF_BYPASS_EN
    // The single outstanding producer is writing back now and nobody re-marks the register.
    always_comb begin
        for (int r = 0; r < NREG; r++) begin
            retire_o[r] = dec[r] && !inc[r] && (cnt_q[r] == CW'(1));
        end
    end
`endif

    assign iss_ready_o = iss_rdy;
    assign wb_err_o    = wb_err_q;

endmodule

// File: rtl/riscv_regfile_sb.sv
// Integer register file: NRD combinational read ports, one write-back port, pending-write scoreboard.
// Latency: reads combinational; a write is visible the cycle after (same cycle with RISCV_RF_BYPASS_EN defined).
// Backpressure: issue is throttled via iss_ready_o from the scoreboard; reads and write-back never stall.
// Ports: clk_i, rst_ni (async active-low), rf (riscv_regfile_sb_if.slave) carrying read/issue/wb/flush and debug taps.
module riscv_regfile_sb
    import riscv_rf_pkg::*;
#(
    parameter int XLEN       = DEF_XLEN,
    parameter int NREG       = 32,
    parameter int NRD        = 2,
    parameter int MAX_PEND   = DEF_MAX_PEND,
    parameter int RESULT_IDX = REG_T4
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    riscv_regfile_sb_if.slave rf
);

    localparam int AW = $clog2(NREG);

    logic [XLEN-1:0] regs_q [NREG];
    logic [XLEN-1:0] regs_d [NREG];
    logic [NREG-1:0] busy;
`ifdef RISCV_RF_BYPASS_EN
    logic [NREG-1:0] retire;
`endif

    riscv_rf_scoreboard #(
        .NREG     (NREG),
        .MAX_PEND (MAX_PEND)
    ) u_sb (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .iss_en_i    (rf.iss_en_i),
        .iss_addr_i  (rf.iss_addr_i),
        .iss_ready_o (rf.iss_ready_o),
        .wb_en_i     (rf.wb_en_i),
        .wb_addr_i   (rf.wb_addr_i),
        .flush_i     (rf.flush_i),
        .busy_o      (busy),
`ifdef RISCV_RF_BYPASS_EN
        .retire_o    (retire),
`endif
        .wb_err_o    (rf.wb_err_o)
    );

    // x0 is never written, so its storage stays at the reset value 0.
    always_comb begin
        for (int r = 0; r < NREG; r++) begin
            regs_d[r] = regs_q[r];
        end
        if (rf.wb_en_i && (rf.wb_addr_i != AW'(REG_ZERO))) begin
            regs_d[rf.wb_addr_i] = rf.wb_data_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int r = 0; r < NREG; r++) begin
                regs_q[r] <= '0;
            end
        end else begin
            for (int r = 0; r < NREG; r++) begin
                regs_q[r] <= regs_d[r];
            end
        end
    end

    always_comb begin
        logic [AW-1:0] a;
        a            = '0;
        rf.rs_data_o = '0;
        rf.rs_busy_o = '0;
        for (int k = 0; k < NRD; k++) begin
            a                                 = rf.rs_addr_i[k*AW +: AW];
            rf.rs_data_o[k*XLEN +: XLEN]      = regs_q[a];
            rf.rs_busy_o[k]                   = busy[a];
`ifdef RISCV_RF_BYPASS_EN
            if (rf.wb_en_i && (rf.wb_addr_i == a) && (a != AW'(REG_ZERO))) begin
                rf.rs_data_o[k*XLEN +: XLEN] = rf.wb_data_i;
            end
            // Retirement already implies a matching non-zero write-back this cycle.
            rf.rs_busy_o[k] = busy[a] && !retire[a];
`endif
        end
    end

    assign rf.busy_o   = busy;
    assign rf.ra_o     = regs_q[REG_RA];
    assign rf.sp_o     = regs_q[REG_SP];
    assign rf.result_o = regs_q[RESULT_IDX];

endmodule

// File: tb/tb_riscv_regfile_sb.sv
// Directed table-driven bench for riscv_regfile_sb plus hand sequences for flush and async reset.
// Latency: inputs driven on the falling edge, outputs sampled 2 ns later, state advances on the rising edge.
// Backpressure: iss_ready_o expectations are part of every vector.
module tb_riscv_regfile_sb;

`ifdef RISCV_RF_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic clk_i  = 1'b0;
    logic rst_ni = 1'b0;

    always #5 clk_i = ~clk_i;

    riscv_regfile_sb_if #(.XLEN(32), .NREG(32), .NRD(2)) rf ();

    riscv_regfile_sb #(
        .XLEN(32), .NREG(32), .NRD(2), .MAX_PEND(3), .RESULT_IDX(29)
    ) dut (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .rf     (rf)
    );

    typedef struct {
        logic [4:0]  a0, a1;
        logic        ie;
        logic [4:0]  ia;
        logic        we;
        logic [4:0]  wa;
        logic [31:0] wd;
        logic [31:0] d0, d1;
        logic        b0, b1, rdy, err;
        logic [31:0] bsy;
    } vec_t;

    vec_t tbl[$];
    int   n_chk = 0;
    int   n_err = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic vec_t mk(
        input logic [4:0] a0, input logic [4:0] a1, input logic ie, input logic [4:0] ia,
        input logic we, input logic [4:0] wa, input logic [31:0] wd,
        input logic [31:0] d0, input logic [31:0] d1, input logic b0, input logic b1,
        input logic rdy, input logic err, input logic [31:0] bsy);
        vec_t v;
        v.a0 = a0; v.a1 = a1; v.ie = ie; v.ia = ia; v.we = we; v.wa = wa; v.wd = wd;
        v.d0 = d0; v.d1 = d1; v.b0 = b0; v.b1 = b1; v.rdy = rdy; v.err = err; v.bsy = bsy;
        return v;
    endfunction

    task automatic drive(input logic [4:0] a0, input logic [4:0] a1, input logic ie, input logic [4:0] ia,
                         input logic we, input logic [4:0] wa, input logic [31:0] wd, input logic fl);
        rf.rs_addr_i  = {a1, a0};
        rf.iss_en_i   = ie;
        rf.iss_addr_i = ia;
        rf.wb_en_i    = we;
        rf.wb_addr_i  = wa;
        rf.wb_data_i  = wd;
        rf.flush_i    = fl;
    endtask

    initial begin
        drive(5'd1, 5'd2, 1'b0, 5'd29, 1'b0, 5'd0, 32'h0, 1'b0);

        //             a0  a1  ie ia  we wa  wd             d0                              d1                      b0           b1   rdy err busy
        tbl.push_back(mk(1,  2,  0, 29, 0, 0,  32'h0,        32'h0,                          32'h0,                  0,           0,   1,  0,  32'h0));
        tbl.push_back(mk(5,  29, 0, 29, 1, 5,  32'hDEADBEEF, BYP ? 32'hDEADBEEF : 32'h0,     32'h0,                  0,           0,   1,  0,  32'h0));
        tbl.push_back(mk(5,  0,  0, 29, 1, 0,  32'h1234,     32'hDEADBEEF,                   32'h0,                  0,           0,   1,  1,  32'h0));
        tbl.push_back(mk(0,  5,  1, 7,  0, 0,  32'h0,        32'h0,                          32'hDEADBEEF,           0,           0,   1,  0,  32'h0));
        tbl.push_back(mk(7,  7,  1, 7,  0, 0,  32'h0,        32'h0,                          32'h0,                  1,           1,   1,  0,  32'h80));
        tbl.push_back(mk(7,  7,  1, 7,  0, 0,  32'h0,        32'h0,                          32'h0,                  1,           1,   1,  0,  32'h80));
        tbl.push_back(mk(7,  7,  1, 7,  0, 0,  32'h0,        32'h0,                          32'h0,                  1,           1,   0,  0,  32'h80));
        tbl.push_back(mk(7,  7,  0, 7,  1, 7,  32'h77,       BYP ? 32'h77 : 32'h0,           BYP ? 32'h77 : 32'h0,   1,           1,   0,  0,  32'h80));
        tbl.push_back(mk(7,  7,  0, 7,  1, 7,  32'h78,       BYP ? 32'h78 : 32'h77,          BYP ? 32'h78 : 32'h77,  1,           1,   1,  0,  32'h80));
        tbl.push_back(mk(7,  7,  0, 7,  1, 7,  32'h79,       BYP ? 32'h79 : 32'h78,          BYP ? 32'h79 : 32'h78,  !BYP,        !BYP, 1, 0,  32'h80));
        tbl.push_back(mk(7,  7,  1, 7,  0, 0,  32'h0,        32'h79,                         32'h79,                 0,           0,   1,  0,  32'h0));
        tbl.push_back(mk(7,  7,  1, 7,  1, 7,  32'h7A,       BYP ? 32'h7A : 32'h79,          BYP ? 32'h7A : 32'h79,  1,           1,   1,  0,  32'h80));
        tbl.push_back(mk(7,  9,  0, 7,  1, 9,  32'h99,       32'h7A,                         BYP ? 32'h99 : 32'h0,   1,           0,   1,  0,  32'h80));
        tbl.push_back(mk(7,  9,  0, 7,  1, 7,  32'h7B,       BYP ? 32'h7B : 32'h7A,          32'h99,                 !BYP,        0,   1,  1,  32'h80));
        tbl.push_back(mk(7,  9,  1, 0,  0, 0,  32'h0,        32'h7B,                         32'h99,                 0,           0,   1,  0,  32'h0));
        tbl.push_back(mk(0,  0,  0, 0,  0, 0,  32'h0,        32'h0,                          32'h0,                  0,           0,   1,  0,  32'h0));

        // Reset state while reset is held.
        #3;
        chk("rst rs_data", rf.rs_data_o[31:0], 32'h0);
        chk("rst rs_data1", rf.rs_data_o[63:32], 32'h0);
        chk("rst rs_busy", {30'h0, rf.rs_busy_o}, 32'h0);
        chk("rst iss_ready", {31'h0, rf.iss_ready_o}, 32'h1);
        chk("rst wb_err", {31'h0, rf.wb_err_o}, 32'h0);
        chk("rst busy", rf.busy_o, 32'h0);
        chk("rst ra", rf.ra_o, 32'h0);
        chk("rst sp", rf.sp_o, 32'h0);
        chk("rst result", rf.result_o, 32'h0);

        @(negedge clk_i);
        rst_ni = 1'b1;

        foreach (tbl[i]) begin
            @(negedge clk_i);
            drive(tbl[i].a0, tbl[i].a1, tbl[i].ie, tbl[i].ia, tbl[i].we, tbl[i].wa, tbl[i].wd, 1'b0);
            #2;
            chk($sformatf("row%0d d0", i), rf.rs_data_o[31:0], tbl[i].d0);
            chk($sformatf("row%0d d1", i), rf.rs_data_o[63:32], tbl[i].d1);
            chk($sformatf("row%0d b0", i), {31'h0, rf.rs_busy_o[0]}, {31'h0, tbl[i].b0});
            chk($sformatf("row%0d b1", i), {31'h0, rf.rs_busy_o[1]}, {31'h0, tbl[i].b1});
            chk($sformatf("row%0d rdy", i), {31'h0, rf.iss_ready_o}, {31'h0, tbl[i].rdy});
            chk($sformatf("row%0d err", i), {31'h0, rf.wb_err_o}, {31'h0, tbl[i].err});
            chk($sformatf("row%0d busy", i), rf.busy_o, tbl[i].bsy);
        end

        // Flush: x3 has two producers, x4 one; flush together with a write-back to x3.
        @(negedge clk_i); drive(5'd3, 5'd4, 1'b1, 5'd3, 1'b0, 5'd0, 32'h0, 1'b0);
        @(negedge clk_i); drive(5'd3, 5'd4, 1'b1, 5'd3, 1'b0, 5'd0, 32'h0, 1'b0);
        @(negedge clk_i); drive(5'd3, 5'd4, 1'b1, 5'd4, 1'b0, 5'd0, 32'h0, 1'b0);
        @(negedge clk_i); drive(5'd3, 5'd4, 1'b0, 5'd3, 1'b0, 5'd0, 32'h0, 1'b0);
        #2;
        chk("pre-flush busy", rf.busy_o, 32'h18);
        chk("pre-flush b1", {31'h0, rf.rs_busy_o[1]}, 32'h1);
        @(negedge clk_i); drive(5'd3, 5'd4, 1'b0, 5'd3, 1'b1, 5'd3, 32'h33, 1'b1);
        @(negedge clk_i); drive(5'd3, 5'd4, 1'b0, 5'd3, 1'b0, 5'd0, 32'h0, 1'b0);
        #2;
        chk("flush busy", rf.busy_o, 32'h0);
        chk("flush x3 data", rf.rs_data_o[31:0], 32'h33);
        chk("flush wb_err", {31'h0, rf.wb_err_o}, 32'h0);
        chk("flush iss_ready", {31'h0, rf.iss_ready_o}, 32'h1);

        // Debug taps, then one pending producer on x5 before an asynchronous reset.
        @(negedge clk_i); drive(5'd3, 5'd4, 1'b0, 5'd0, 1'b1, 5'd1, 32'h11, 1'b0);
        @(negedge clk_i); drive(5'd3, 5'd4, 1'b0, 5'd0, 1'b1, 5'd2, 32'h22, 1'b0);
        @(negedge clk_i); drive(5'd3, 5'd4, 1'b0, 5'd0, 1'b1, 5'd29, 32'h29, 1'b0);
        @(negedge clk_i); drive(5'd3, 5'd4, 1'b1, 5'd5, 1'b0, 5'd0, 32'h0, 1'b0);
        @(negedge clk_i); drive(5'd3, 5'd5, 1'b0, 5'd5, 1'b0, 5'd0, 32'h0, 1'b0);
        #2;
        chk("tap ra", rf.ra_o, 32'h11);
        chk("tap sp", rf.sp_o, 32'h22);
        chk("tap result", rf.result_o, 32'h29);
        chk("pre-rst busy", rf.busy_o, 32'h20);
        chk("pre-rst b1", {31'h0, rf.rs_busy_o[1]}, 32'h1);
        #1 rst_ni = 1'b0;
        #1;
        chk("arst ra", rf.ra_o, 32'h0);
        chk("arst sp", rf.sp_o, 32'h0);
        chk("arst result", rf.result_o, 32'h0);
        chk("arst rs_data", rf.rs_data_o[31:0], 32'h0);
        chk("arst busy", rf.busy_o, 32'h0);
        chk("arst b1", {31'h0, rf.rs_busy_o[1]}, 32'h0);
        chk("arst iss_ready", {31'h0, rf.iss_ready_o}, 32'h1);
        chk("arst wb_err", {31'h0, rf.wb_err_o}, 32'h0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
